chip_test_sequencer: RTL and testbench

Sequences the per-chip tester blocks (one tester per supported 74xx part, each with a Run/Done/RSLT/DISP_RSLT handshake) so they share one start button and one result display. It either launches the single tester picked by `Chip_Sel` or sweeps all testers in order. It collects the pass/fail verdicts and holds them for the display logic. It sits between the board switches/buttons and the bank of chip testers.

---
 rtl/chip_seq_pkg.sv | 22 ++
 rtl/start_edge_detect.sv | 29 ++
 rtl/chip_test_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_chip_test_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip_seq_pkg.sv
// Shared types and defaults for the chip test sequencer.
package chip_seq_pkg;

    localparam int unsigned N_CHIPS_DEF     = 8;
    localparam int unsigned TIMEOUT_CYC_DEF = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_DONE,
        ST_CAPTURE,
        ST_RELEASE,
        ST_DRAIN,
        ST_REPORT
    } state_e;

    // Busy covers every state where a tester is owned by the sequencer.
    function automatic logic is_busy(state_e s);
        return !((s == ST_IDLE) || (s == ST_REPORT));
    endfunction

endpackage

// File: rtl/start_edge_detect.sv
// Registered rising-edge detector for the (already synchronized) Start button.
module start_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic start_rise
);

    logic start_q, start_d;
    logic rise_q, rise_d;

    always_comb begin
        start_d = start;
        rise_d  = start & ~start_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            start_q <= start_d;
            rise_q  <= rise_d;
        end
    end

    assign start_rise = rise_q;

endmodule

// File: rtl/chip_test_sequencer.sv
// Launches one or all 74xx testers through Run/Done/RSLT/DISP_RSLT and collects verdicts.
// Optional WAIT_DONE watchdog: define CHIP_SEQ_TIMEOUT_EN.
module chip_test_sequencer
    import chip_seq_pkg::*;
#(
    parameter int unsigned N_CHIPS     = N_CHIPS_DEF,
    parameter int unsigned SEL_W       = $clog2(N_CHIPS),
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Start,
    input  logic               Sweep,
    input  logic [SEL_W-1:0]   Chip_Sel,
    output logic [N_CHIPS-1:0] Run_Vec,
    input  logic [N_CHIPS-1:0] Done_Vec,
    input  logic [N_CHIPS-1:0] RSLT_Vec,
    output logic [N_CHIPS-1:0] DISP_RSLT_Vec,
    output logic               Busy,
    output logic [SEL_W-1:0]   Cur_Chip,
    output logic               Result_Valid,
    output logic [N_CHIPS-1:0] Pass_Mask,
    output logic [N_CHIPS-1:0] Tested_Mask,
    output logic [N_CHIPS-1:0] Timeout_Mask,
    output logic               Sel_Err
);

    if ((N_CHIPS < 2) || (TIMEOUT_CYC < 2)) begin : g_bad_params
        $error("chip_test_sequencer: N_CHIPS and TIMEOUT_CYC must be at least 2");
    end

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [SEL_W-1:0]   sel_s_q, sel_s_d;
    logic               sweep_s_q, sweep_s_d;
    logic               sweep_q, sweep_d;
    logic [N_CHIPS-1:0] pass_q, pass_d;
    logic [N_CHIPS-1:0] tested_q, tested_d;
    logic [N_CHIPS-1:0] run_q, run_d;
    logic [N_CHIPS-1:0] disp_q, disp_d;
    logic               sel_err_q, sel_err_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;

    logic               start_rise;
    logic [N_CHIPS-1:0] sel_oh_c;
    logic               done_sel_c;
    logic               rslt_sel_c;
    logic               more_c;

`ifdef CHIP_SEQ_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_CHIPS-1:0] tmo_q, tmo_d;
    logic               tmo_hit_q, tmo_hit_d;
`endif

    start_edge_detect u_start_edge (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .start      (Start),
        .start_rise (start_rise)
    );

    // Only the active tester's Done/RSLT are ever observed.
    assign sel_oh_c   = N_CHIPS'(1) << idx_q;
    assign done_sel_c = |(Done_Vec & sel_oh_c);
    assign rslt_sel_c = |(RSLT_Vec & sel_oh_c);
    assign more_c     = sweep_q && (32'(idx_q) < (N_CHIPS - 1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sweep_d   = sweep_q;
        pass_d    = pass_q;
        tested_d  = tested_q;
        sel_err_d = sel_err_q;
        // Mode inputs are delayed one cycle so they line up with the registered edge.
        sel_s_d   = Chip_Sel;
        sweep_s_d = Sweep;
`ifdef CHIP_SEQ_TIMEOUT_EN
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        tmo_hit_d = tmo_hit_q;
`endif

        case (state_q)
            ST_IDLE, ST_REPORT: begin
                if (start_rise) begin
                    pass_d    = '0;
                    tested_d  = '0;
                    sel_err_d = 1'b0;
                    sweep_d   = sweep_s_q;
`ifdef CHIP_SEQ_TIMEOUT_EN
                    tmo_d     = '0;
`endif
                    if (sweep_s_q) begin
                        idx_d   = '0;
                        state_d = ST_LAUNCH;
                    end else if (32'(sel_s_q) >= N_CHIPS) begin
                        idx_d     = '0;
                        sel_err_d = 1'b1;
                        state_d   = ST_REPORT;
                    end else begin
                        idx_d   = sel_s_q;
                        state_d = ST_LAUNCH;
                    end
                end
            end

            ST_LAUNCH: begin
`ifdef CHIP_SEQ_TIMEOUT_EN
                cnt_d     = '0;
                tmo_hit_d = 1'b0;
`endif
                state_d = ST_WAIT_DONE;
            end

            ST_WAIT_DONE: begin
                if (done_sel_c) begin
                    state_d = ST_CAPTURE;
                end
`ifdef CHIP_SEQ_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    tmo_d     = tmo_q | sel_oh_c;
                    pass_d    = pass_q & ~sel_oh_c;
                    tested_d  = tested_q | sel_oh_c;
                    tmo_hit_d = 1'b1;
                    state_d   = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end

            ST_CAPTURE: begin
                pass_d   = rslt_sel_c ? (pass_q | sel_oh_c) : (pass_q & ~sel_oh_c);
                tested_d = tested_q | sel_oh_c;
                state_d  = ST_RELEASE;
            end

            ST_RELEASE: begin
                state_d = ST_DRAIN;
`ifdef CHIP_SEQ_TIMEOUT_EN
                // A timed-out tester never raised Done, so there is nothing to drain.
                if (tmo_hit_q) begin
                    if (more_c) begin
                        idx_d   = idx_q + SEL_W'(1);
                        state_d = ST_LAUNCH;
                    end else begin
                        state_d = ST_REPORT;
                    end
                end
`endif
            end

            ST_DRAIN: begin
                if (!done_sel_c) begin
                    if (more_c) begin
                        idx_d   = idx_q + SEL_W'(1);
                        state_d = ST_LAUNCH;
                    end else begin
                        state_d = ST_REPORT;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Pulses and status are registered from the next state so they align with it.
        run_d   = (state_d == ST_LAUNCH)  ? (N_CHIPS'(1) << idx_d) : '0;
        disp_d  = (state_d == ST_RELEASE) ? (N_CHIPS'(1) << idx_d) : '0;
        busy_d  = is_busy(state_d);
        valid_d = (state_d == ST_REPORT);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            sel_s_q   <= '0;
            sweep_s_q <= 1'b0;
            sweep_q   <= 1'b0;
            pass_q    <= '0;
            tested_q  <= '0;
            run_q     <= '0;
            disp_q    <= '0;
            sel_err_q <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sel_s_q   <= sel_s_d;
            sweep_s_q <= sweep_s_d;
            sweep_q   <= sweep_d;
            pass_q    <= pass_d;
            tested_q  <= tested_d;
            run_q     <= run_d;
            disp_q    <= disp_d;
            sel_err_q <= sel_err_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
        end
    end

`ifdef CHIP_SEQ_TIMEOUT_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q     <= '0;
            tmo_q     <= '0;
            tmo_hit_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            tmo_hit_q <= tmo_hit_d;
        end
    end

    assign Timeout_Mask = tmo_q;
`else
    assign Timeout_Mask = '0;
`endif

    assign Run_Vec       = run_q;
    assign DISP_RSLT_Vec = disp_q;
    assign Busy          = busy_q;
    assign Cur_Chip      = idx_q;
    assign Result_Valid  = valid_q;
    assign Pass_Mask     = pass_q;
    assign Tested_Mask   = tested_q;
    assign Sel_Err       = sel_err_q;

endmodule

// File: tb/tb_chip_test_sequencer.sv
// Scoreboard bench for chip_test_sequencer: behavioural tester models plus queued expectations.
module tb_chip_test_sequencer;

    localparam int unsigned N      = 8;
    localparam int unsigned SW     = 4;
    localparam int unsigned TMO    = 16;
    localparam int          BUDGET = 400;
`ifdef CHIP_SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef struct packed {
        logic [N-1:0] pass;
        logic [N-1:0] tested;
        logic [N-1:0] tmo;
        logic         sel_err;
    } rep_t;

    logic          clk, rst_n, Start, Sweep;
    logic [SW-1:0] Chip_Sel, Cur_Chip;
    logic [N-1:0]  Run_Vec, Done_Vec, RSLT_Vec, DISP_RSLT_Vec;
    logic [N-1:0]  Pass_Mask, Tested_Mask, Timeout_Mask;
    logic          Busy, Result_Valid, Sel_Err;

    chip_test_sequencer #(.N_CHIPS(N), .SEL_W(SW), .TIMEOUT_CYC(TMO)) dut (
        .Clk(clk), .Reset_n(rst_n), .Start(Start), .Sweep(Sweep), .Chip_Sel(Chip_Sel),
        .Run_Vec(Run_Vec), .Done_Vec(Done_Vec), .RSLT_Vec(RSLT_Vec),
        .DISP_RSLT_Vec(DISP_RSLT_Vec), .Busy(Busy), .Cur_Chip(Cur_Chip),
        .Result_Valid(Result_Valid), .Pass_Mask(Pass_Mask), .Tested_Mask(Tested_Mask),
        .Timeout_Mask(Timeout_Mask), .Sel_Err(Sel_Err)
    );

    int   n_chk = 0, n_fail = 0;
    int   cyc = 0, start_cyc = 0, run_cyc = 0;
    bit   run_seen = 0;
    bit   rv_prev = 0;
    int   exp_run_q[$], exp_disp_q[$];
    rep_t exp_rep_q[$];
    int   mon_i;
    rep_t mon_r;

    int unsigned cfg_delay[N], cfg_drop[N];
    bit          cfg_rslt[N], cfg_hang[N];
    int unsigned t_cnt[N], t_dcnt[N];
    bit          t_act[N], t_rel[N];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Tester models: Done rises cfg_delay cycles after Run, falls cfg_drop cycles after DISP_RSLT.
    always @(negedge clk) begin
        if (!rst_n) begin
            Done_Vec = '0;
            RSLT_Vec = '0;
            for (int i = 0; i < N; i++) begin
                t_act[i] = 1'b0;
                t_rel[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (Run_Vec[i] && !cfg_hang[i]) begin
                    t_act[i] = 1'b1;
                    t_cnt[i] = cfg_delay[i];
                end
                if (t_act[i]) begin
                    if (t_cnt[i] == 0) begin
                        Done_Vec[i] = 1'b1;
                        RSLT_Vec[i] = cfg_rslt[i];
                        t_act[i]    = 1'b0;
                    end else begin
                        t_cnt[i]--;
                    end
                end
                if (DISP_RSLT_Vec[i]) begin
                    t_rel[i]  = 1'b1;
                    t_dcnt[i] = cfg_drop[i];
                end
                if (t_rel[i]) begin
                    if (t_dcnt[i] == 0) begin
                        Done_Vec[i] = 1'b0;
                        t_rel[i]    = 1'b0;
                    end else begin
                        t_dcnt[i]--;
                    end
                end
                if (!Done_Vec[i]) RSLT_Vec[i] = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a pulse or a new report.
    always @(negedge clk) begin
        if (!rst_n) begin
            rv_prev = 1'b0;
        end else begin
            if (Run_Vec != '0) begin
                if (!run_seen) begin
                    run_seen = 1'b1;
                    run_cyc  = cyc;
                end
                if (exp_run_q.size() == 0) begin
                    chk("run_unexpected", 64'(Run_Vec), 64'(0));
                end else begin
                    mon_i = exp_run_q.pop_front();
                    chk("run_vec", 64'(Run_Vec), 64'(N'(1) << mon_i));
                    chk("cur_chip", 64'(Cur_Chip), 64'(mon_i));
                end
            end
            if (DISP_RSLT_Vec != '0) begin
                if (exp_disp_q.size() == 0) begin
                    chk("disp_unexpected", 64'(DISP_RSLT_Vec), 64'(0));
                end else begin
                    mon_i = exp_disp_q.pop_front();
                    chk("disp_vec", 64'(DISP_RSLT_Vec), 64'(N'(1) << mon_i));
                end
            end
            if (Result_Valid && !rv_prev) begin
                if (exp_rep_q.size() == 0) begin
                    chk("report_unexpected", 64'(Result_Valid), 64'(0));
                end else begin
                    mon_r = exp_rep_q.pop_front();
                    chk("pass_mask", 64'(Pass_Mask), 64'(mon_r.pass));
                    chk("tested_mask", 64'(Tested_Mask), 64'(mon_r.tested));
                    chk("timeout_mask", 64'(Timeout_Mask), 64'(mon_r.tmo));
                    chk("sel_err", 64'(Sel_Err), 64'(mon_r.sel_err));
                    chk("busy_in_report", 64'(Busy), 64'(0));
                end
            end
            rv_prev = Result_Valid;
        end
    end

    // Reference model: which testers a run touches and what the report must say.
    task automatic model_run(input bit sw, input int unsigned sel);
        rep_t r;
        int   lo, hi;
        r = '0;
        if (!sw && sel >= N) begin
            r.sel_err = 1'b1;
            exp_rep_q.push_back(r);
            return;
        end
        lo = sw ? 0 : int'(sel);
        hi = sw ? int'(N) - 1 : int'(sel);
        for (int i = lo; i <= hi; i++) begin
            exp_run_q.push_back(i);
            exp_disp_q.push_back(i);
            r.tested[i] = 1'b1;
            if (TMO_EN && cfg_hang[i]) r.tmo[i] = 1'b1;
            else                       r.pass[i] = cfg_rslt[i];
        end
        exp_rep_q.push_back(r);
    endtask

    task automatic randomize_cfg(input int unsigned min_delay);
        for (int i = 0; i < N; i++) begin
            cfg_delay[i] = $urandom_range(20, min_delay);
            cfg_drop[i]  = $urandom_range(0, 3);
            cfg_rslt[i]  = 1'($urandom_range(0, 1));
            cfg_hang[i]  = TMO_EN && ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic press(input bit sw, input int unsigned sel);
        model_run(sw, sel);
        @(negedge clk);
        Sweep     = sw;
        Chip_Sel  = SW'(sel);
        Start     = 1'b1;
        start_cyc = cyc;
        run_seen  = 1'b0;
        @(negedge clk);
        Start = 1'b0;
    endtask

    task automatic wait_report();
        int k;
        k = 0;
        @(negedge clk);
        while (!(Result_Valid && !Busy) && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        chk("report_reached", 64'(Result_Valid), 64'(1));
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {Run_Vec, DISP_RSLT_Vec, Busy, Cur_Chip, Result_Valid, Pass_Mask,
                 Tested_Mask, Timeout_Mask, Sel_Err}, 64'(0));
    endtask

    initial begin
        rst_n = 1'b0; Start = 1'b0; Sweep = 1'b0; Chip_Sel = '0;
        Done_Vec = '0; RSLT_Vec = '0;
        for (int i = 0; i < N; i++) begin
            cfg_delay[i] = 5; cfg_drop[i] = 0; cfg_rslt[i] = 1'b1; cfg_hang[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk_all_zero("reset_state");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Invalid select from IDLE: straight to REPORT, no Run.
        press(1'b0, 9);
        @(negedge clk);
        chk("sel_err_report_t2", 64'({Result_Valid, Sel_Err}), 64'(2'b11));
        repeat (4) @(negedge clk);
        chk("sel_err_no_run", 64'(run_seen), 64'(0));

        // Single pass on chip 2, Done after 17 cycles.
        cfg_delay[2] = 17; cfg_rslt[2] = 1'b1;
        press(1'b0, 2);
        wait_report();
        chk("single_pass_mask", 64'(Pass_Mask), 64'(8'h04));
        chk("single_tested_mask", 64'(Tested_Mask), 64'(8'h04));
        chk("run_latency", 64'(run_cyc - start_cyc), 64'(2));

        // Sweep with chip 5 failing.
        for (int i = 0; i < N; i++) begin
            cfg_delay[i] = $urandom_range(12, 1); cfg_rslt[i] = 1'b1; cfg_drop[i] = $urandom_range(0, 3);
        end
        cfg_rslt[5] = 1'b0;
        press(1'b1, 0);
        wait_report();
        chk("sweep_pass_mask", 64'(Pass_Mask), 64'(8'hDF));
        chk("sweep_tested_mask", 64'(Tested_Mask), 64'(8'hFF));

`ifdef CHIP_SEQ_TIMEOUT_EN
        // Chip 3 never answers: timeout flagged, sweep carries on.
        for (int i = 0; i < N; i++) begin
            cfg_delay[i] = 3; cfg_rslt[i] = 1'b1; cfg_hang[i] = 1'b0;
        end
        cfg_hang[3] = 1'b1;
        press(1'b1, 0);
        wait_report();
        chk("tmo_timeout_mask", 64'(Timeout_Mask), 64'(8'h08));
        chk("tmo_pass_mask", 64'(Pass_Mask), 64'(8'hF7));
        cfg_hang[3] = 1'b0;
`endif

        // Start re-pressed during WAIT_DONE must be ignored.
        randomize_cfg(8);
        press(1'b1, 0);
        for (int k = 0; k < BUDGET && !run_seen; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        Sweep = 1'b0; Chip_Sel = SW'(5); Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        wait_report();

        // Randomized runs back to back from REPORT.
        for (int n = 0; n < 12; n++) begin
            randomize_cfg(0);
            press(1'($urandom_range(0, 1)), $urandom_range(0, N - 1));
            wait_report();
            chk("rand_run_latency", 64'(run_cyc - start_cyc), 64'(2));
        end

        // Reset during RELEASE of chip 1.
        randomize_cfg(2);
        for (int i = 0; i < N; i++) cfg_hang[i] = 1'b0;
        press(1'b1, 0);
        for (int k = 0; k < BUDGET && !DISP_RSLT_Vec[1]; k++) @(negedge clk);
        chk("disp1_seen", 64'(DISP_RSLT_Vec), 64'(8'h02));
        #1 rst_n = 1'b0;
        #1 chk_all_zero("reset_mid_run");
        exp_run_q.delete(); exp_disp_q.delete(); exp_rep_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        randomize_cfg(0);
        press(1'b1, 0);
        wait_report();

        chk("run_q_empty", 64'(exp_run_q.size()), 64'(0));
        chk("disp_q_empty", 64'(exp_disp_q.size()), 64'(0));
        chk("rep_q_empty", 64'(exp_rep_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
